// File: rtl/spi_rdid_pkg.sv
`timescale 1ns/1ps
// Shared constants and encodings for the M25P16 RDID reader.
package spi_rdid_pkg;

    localparam logic [7:0]  RDID_CMD_DEFAULT = 8'h9F;
    localparam int unsigned CMD_BITS         = 8;
    localparam int unsigned ID_BITS          = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_READ,
        ST_DONE
    } rdid_state_e;

    typedef enum logic [1:0] {
        SEL_CAP    = 2'b00,
        SEL_TYPE   = 2'b01,
        SEL_MAN    = 2'b10,
        SEL_ALL_ON = 2'b11
    } led_sel_e;

endpackage

// File: rtl/spi_rdid_debounce.sv
`timescale 1ns/1ps
// Two-flop synchronizer followed by a lock-out debouncer; emits a one-cycle
// pulse on each rising edge of the debounced level.
module spi_rdid_debounce #(
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise_pulse
);

    logic                     sync1_q, sync2_q;
    logic                     db_q, db_d;
    logic                     lock_q, lock_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     pulse_q, pulse_d;

    always_comb begin
        db_d   = db_q;
        lock_d = lock_q;
        cnt_d  = cnt_q;
        if (!lock_q) begin
            if (sync2_q != db_q) begin
                db_d   = sync2_q;
                lock_d = 1'b1;
                cnt_d  = '0;
            end
        end else if (cnt_q == '1) begin
            // Lock-out expired: catch up with a level that changed meanwhile.
            cnt_d = '0;
            if (sync2_q != db_q) begin
                db_d = sync2_q;
            end else begin
                lock_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        pulse_d = db_d & ~db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign rise_pulse = pulse_q;

endmodule

// File: rtl/spi_rdid_ledmux.sv
`timescale 1ns/1ps
// Selects which ID byte is shown on the LEDs.
module spi_rdid_ledmux
    import spi_rdid_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [7:0] man_id,
    input  logic [7:0] mem_type,
    input  logic [7:0] mem_cap,
    output logic [7:0] led
);

    always_comb begin
        led = '1;
        case (sel)
            SEL_CAP:    led = mem_cap;
            SEL_TYPE:   led = mem_type;
            SEL_MAN:    led = man_id;
            SEL_ALL_ON: led = '1;
            default:    led = '1;
        endcase
    end

endmodule

// File: rtl/spi_rdid_top.sv
`timescale 1ns/1ps
// Button-triggered JEDEC RDID read of an M25P16 over SPI mode 0, with the
// three returned ID bytes shown on eight LEDs.
module spi_rdid_top
    import spi_rdid_pkg::*;
#(
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter logic [7:0]  RDID_CMD      = RDID_CMD_DEFAULT
) (
    input  logic       CCLK,
    input  logic       rst_n,
    input  logic       reset_btn,
    input  logic       get_rdid_btn,
    input  logic [1:0] SW,
    input  logic       SPIMISO,
    output logic       SPICLK,
    output logic       SPIMOSI,
    output logic       chip_select,
    output logic       LD0,
    output logic       LD1,
    output logic       LD2,
    output logic       LD3,
    output logic       LD4,
    output logic       LD5,
    output logic       LD6,
    output logic       LD7
);

    logic        clr_pulse, get_pulse;
    rdid_state_e state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  cmd_sr_q, cmd_sr_d;
    logic [23:0] rx_sr_q, rx_sr_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  man_q, man_d, typ_q, typ_d, cap_q, cap_d;
    logic [7:0]  LED;

    spi_rdid_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_reset_db (
        .clk        (CCLK),
        .rst_n      (rst_n),
        .btn_raw    (reset_btn),
        .rise_pulse (clr_pulse)
    );

    spi_rdid_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_get_db (
        .clk        (CCLK),
        .rst_n      (rst_n),
        .btn_raw    (get_rdid_btn),
        .rise_pulse (get_pulse)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_sr_d  = cmd_sr_q;
        rx_sr_d   = rx_sr_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        man_d     = man_q;
        typ_d     = typ_q;
        cap_d     = cap_q;
        if (clr_pulse) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
            mosi_d    = 1'b0;
            cs_n_d    = 1'b1;
            man_d     = '0;
            typ_d     = '0;
            cap_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (get_pulse) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        cs_n_d    = 1'b0;
                        sclk_d    = 1'b0;
                        mosi_d    = RDID_CMD[7];
                        cmd_sr_d  = RDID_CMD[6:0];
                    end
                end
                ST_CMD: begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling SPICLK: present the next command bit.
                        sclk_d   = 1'b0;
                        mosi_d   = cmd_sr_q[6];
                        cmd_sr_d = {cmd_sr_q[5:0], 1'b0};
                        if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = ST_READ;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[22:0], SPIMISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 5'(ID_BITS - 1)) begin
                            bit_cnt_d = '0;
                            cs_n_d    = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    man_d   = rx_sr_q[23:16];
                    typ_d   = rx_sr_q[15:8];
                    cap_d   = rx_sr_q[7:0];
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            cmd_sr_q  <= '0;
            rx_sr_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            man_q     <= '0;
            typ_q     <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            rx_sr_q   <= rx_sr_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            man_q     <= man_d;
            typ_q     <= typ_d;
            cap_q     <= cap_d;
        end
    end

    spi_rdid_ledmux ledMux (
        .sel      (SW),
        .man_id   (man_q),
        .mem_type (typ_q),
        .mem_cap  (cap_q),
        .led      (LED)
    );

    assign SPICLK      = sclk_q;
    assign SPIMOSI     = mosi_q;
    assign chip_select = cs_n_q;
    assign {LD7, LD6, LD5, LD4, LD3, LD2, LD1, LD0} = LED;

endmodule

// File: tb/tb_spi_rdid_top.sv
`timescale 1ns/1ps
// Self-checking bench: behavioural SPI flash plus an ID/LED reference model.
module tb_spi_rdid_top;

    localparam int unsigned DB_BITS  = 4;
    localparam int unsigned LOCK_CYC = 1 << DB_BITS;

    typedef struct {
        logic [1:0] sw;
        logic [7:0] led;
    } vec_t;

    logic       CCLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       reset_btn = 1'b0;
    logic       get_rdid_btn = 1'b0;
    logic [1:0] SW = 2'b00;
    logic       SPIMISO;
    logic       SPICLK, SPIMOSI, chip_select;
    logic       LD0, LD1, LD2, LD3, LD4, LD5, LD6, LD7;
    logic [7:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    // Flash model state
    logic [23:0] flash_id = 24'h202015;
    logic [23:0] flash_sr;
    logic        flash_miso;
    logic [7:0]  cmd_rx, last_cmd;
    int          cur_rise = 0, last_rise = 0;
    int          txn_count = 0, full_count = 0, stray_rises = 0;
    time         first_t, last_t, last_span;

    // Reference model: the ID bytes the LEDs should currently reflect
    logic [23:0] m_id = 24'h0;

    assign led     = {LD7, LD6, LD5, LD4, LD3, LD2, LD1, LD0};
    assign SPIMISO = flash_miso;

    spi_rdid_top #(.DEBOUNCE_BITS(DB_BITS), .RDID_CMD(8'h9F)) dut (
        .CCLK         (CCLK),
        .rst_n        (rst_n),
        .reset_btn    (reset_btn),
        .get_rdid_btn (get_rdid_btn),
        .SW           (SW),
        .SPIMISO      (SPIMISO),
        .SPICLK       (SPICLK),
        .SPIMOSI      (SPIMOSI),
        .chip_select  (chip_select),
        .LD0          (LD0),
        .LD1          (LD1),
        .LD2          (LD2),
        .LD3          (LD3),
        .LD4          (LD4),
        .LD5          (LD5),
        .LD6          (LD6),
        .LD7          (LD7)
    );

    always #10 CCLK = ~CCLK;

    // M25P16 behaviour: shift in opcode on rising SPICLK, drive ID on falling.
    initial begin
        flash_miso = 1'b0;
        flash_sr   = '0;
        cmd_rx     = '0;
        last_cmd   = '0;
        first_t    = 0;
        last_t     = 0;
        last_span  = 0;
        forever begin
            @(negedge chip_select);
            cur_rise = 0;
            cmd_rx   = '0;
            flash_sr = flash_id;
            while (chip_select == 1'b0) begin
                @(posedge SPICLK or posedge chip_select);
                if (chip_select) break;
                if (cur_rise < 8) cmd_rx = {cmd_rx[6:0], SPIMOSI};
                if (cur_rise == 0) first_t = $time;
                last_t = $time;
                cur_rise++;
                @(negedge SPICLK or posedge chip_select);
                if (chip_select) break;
                if (cur_rise >= 8 && cur_rise < 32) begin
                    flash_miso = flash_sr[23];
                    flash_sr   = {flash_sr[22:0], 1'b0};
                end
            end
            flash_miso = 1'b0;
            last_rise  = cur_rise;
            last_cmd   = cmd_rx;
            last_span  = last_t - first_t;
            if (cur_rise == 32) full_count++;
            txn_count++;
        end
    end

    always @(posedge SPICLK) begin
        if (chip_select) stray_rises++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_led(input logic [1:0] sw);
        logic [7:0] by_sel [4];
        by_sel[0] = m_id[7:0];
        by_sel[1] = m_id[15:8];
        by_sel[2] = m_id[23:16];
        by_sel[3] = 8'hFF;
        return by_sel[sw];
    endfunction

    task automatic check_led_table(input string name);
        vec_t vt [4];
        for (int i = 0; i < 4; i++) begin
            vt[i].sw  = 2'(i);
            vt[i].led = exp_led(2'(i));
        end
        for (int i = 0; i < 4; i++) begin
            SW = vt[i].sw;
            #2;
            check(name, {24'h0, led}, {24'h0, vt[i].led});
        end
    endtask

    task automatic drive_btn(input bit is_reset, input logic v);
        if (is_reset) reset_btn = v;
        else          get_rdid_btn = v;
    endtask

    // Short 0.5 ns-granular contact bounce, then settle at the requested level.
    task automatic bounce_to(input bit is_reset, input logic level);
        int unsigned n;
        n = $urandom_range(3, 8);
        for (int unsigned i = 0; i < n; i++) begin
            drive_btn(is_reset, 1'($urandom_range(0, 1)));
            #($urandom_range(1, 15) * 0.5);
        end
        drive_btn(is_reset, level);
    endtask

    task automatic wait_full(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (full_count < target && k < budget) begin
            @(posedge CCLK);
            k++;
        end
        check(name, full_count, target);
    endtask

    task automatic wait_rise(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (!(chip_select == 1'b0 && cur_rise >= n) && k < budget) begin
            @(posedge CCLK);
            k++;
        end
        check(name, {31'h0, (chip_select == 1'b0 && cur_rise >= n)}, 32'h1);
    endtask

    task automatic wait_cs_high(input int budget, input string name);
        int k;
        k = 0;
        while (chip_select !== 1'b1 && k < budget) begin
            @(posedge CCLK);
            k++;
        end
        @(negedge CCLK);
        check(name, {31'h0, chip_select}, 32'h1);
    endtask

    // One complete button-triggered read with protocol and display checks.
    task automatic do_read(input logic [23:0] id);
        int base_txn, base_full;
        flash_id  = id;
        base_txn  = txn_count;
        base_full = full_count;
        bounce_to(1'b0, 1'b1);
        wait_rise(16, 120, "read_started");
        SW = 2'($urandom_range(0, 3));
        #2;
        check("led_stable_mid_read", {24'h0, led}, {24'h0, exp_led(SW)});
        wait_full(base_full + 1, 120, "read_completed");
        check("rise_count", last_rise, 32);
        check("mosi_opcode", {24'h0, last_cmd}, 32'h9F);
        check("spiclk_span_ns", 32'(last_span), 32'd1240);
        repeat (4) @(posedge CCLK);
        m_id = id;
        check_led_table("led_after_read");
        repeat (LOCK_CYC) @(posedge CCLK);
        bounce_to(1'b0, 1'b0);
        repeat (4 * LOCK_CYC) @(posedge CCLK);
        @(negedge CCLK);
        check("single_txn", txn_count - base_txn, 1);
        check("cs_idle_after_release", {31'h0, chip_select}, 32'h1);
    endtask

    initial begin
        vec_t rv [4];
        int   base_txn, base_full;
        rv[0] = '{sw: 2'b00, led: 8'h00};
        rv[1] = '{sw: 2'b01, led: 8'h00};
        rv[2] = '{sw: 2'b10, led: 8'h00};
        rv[3] = '{sw: 2'b11, led: 8'hFF};

        rst_n = 1'b0;
        repeat (3) @(posedge CCLK);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge CCLK);
        @(negedge CCLK);

        for (int i = 0; i < 4; i++) begin
            SW = rv[i].sw;
            #2;
            check("reset_led", {24'h0, led}, {24'h0, rv[i].led});
        end
        check("reset_cs", {31'h0, chip_select}, 32'h1);
        check("reset_sclk", {31'h0, SPICLK}, 32'h0);
        check("reset_mosi", {31'h0, SPIMOSI}, 32'h0);

        do_read(24'h202015);
        for (int i = 0; i < 4; i++) do_read(24'($urandom));
        do_read(24'h202015);

        // Soft clear while a read is in flight
        flash_id  = 24'($urandom) | 24'h1;
        base_full = full_count;
        bounce_to(1'b0, 1'b1);
        wait_rise(12, 120, "abort_read_started");
        bounce_to(1'b1, 1'b1);
        wait_cs_high(12, "soft_clear_cs");
        check("soft_clear_sclk", {31'h0, SPICLK}, 32'h0);
        check("soft_clear_partial", {31'h0, (last_rise < 32)}, 32'h1);
        m_id = 24'h0;
        check_led_table("led_after_soft_clear");
        bounce_to(1'b0, 1'b0);
        bounce_to(1'b1, 1'b0);
        repeat (4 * LOCK_CYC) @(posedge CCLK);
        @(negedge CCLK);
        check("no_read_after_clear", full_count - base_full, 0);
        check("cs_high_after_clear", {31'h0, chip_select}, 32'h1);

        // Asynchronous reset in the middle of a read
        do_read(24'($urandom) | 24'h010000);
        flash_id = 24'($urandom);
        base_txn = txn_count;
        SW       = 2'b10;
        bounce_to(1'b0, 1'b1);
        wait_rise(6, 120, "async_read_started");
        bounce_to(1'b0, 1'b0);
        @(posedge CCLK);
        #3 rst_n = 1'b0;
        #1;
        m_id = 24'h0;
        check("async_cs", {31'h0, chip_select}, 32'h1);
        check("async_sclk", {31'h0, SPICLK}, 32'h0);
        check("async_mosi", {31'h0, SPIMOSI}, 32'h0);
        check("async_led_man", {24'h0, led}, 32'h0);
        SW = 2'b00;
        #1;
        check("async_led_cap", {24'h0, led}, 32'h0);
        repeat (3) @(posedge CCLK);
        #3 rst_n = 1'b1;
        repeat (4 * LOCK_CYC) @(posedge CCLK);
        @(negedge CCLK);
        check("async_one_aborted_txn", txn_count - base_txn, 1);
        check("async_cs_idle", {31'h0, chip_select}, 32'h1);
        check_led_table("led_after_async_reset");
        check("no_stray_spiclk", stray_rises, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_rdid_top.md
Name: spi_rdid_top

Overview:
Board-level top that reads the JEDEC identification of an M25P16 serial flash with the RDID command (0x9F) over SPI when a button is pressed. Holds the three returned ID bytes and shows one of them on eight LEDs, chosen by two switches. Sits between the board pins (CCLK, buttons, switches, LEDs) and the flash SPI pins.

Parameters:
- DEBOUNCE_BITS, 16, debounce lock-out length is 2^DEBOUNCE_BITS CCLK cycles (1.31 ms at 50 MHz).
- RDID_CMD, 8'h9F, command byte sent to the flash.

Ports:
- CCLK  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- reset_btn  in  1  raw bouncy button; soft-clear request.
- get_rdid_btn  in  1  raw bouncy button; starts one RDID read.
- SW  in  2  LED source select.
- SPIMISO  in  1  flash serial data out.
- SPICLK  out  1  SPI clock, mode 0, idle low.
- SPIMOSI  out  1  SPI data to flash.
- chip_select  out  1  flash select, active low.
- LD0..LD7  out  1 each  LED[0]..LED[7].

Behaviour:
- Reset (rst_n=0): chip_select=1, SPICLK=0, SPIMOSI=0, FSM IDLE. All ID registers 0x00, debouncers clear and unlocked.
- Button inputs pass through a 2-FF synchronizer.
- Debouncer, per button:
  - When not locked out, a change of the synchronized input flips the debounced level on the next cycle and starts a 2^DEBOUNCE_BITS-cycle lock-out.
  - Changes during lock-out are ignored.
  - At lock-out expiry, if input differs from the debounced level, it flips again and re-locks.
  - A rising edge of the debounced level gives a 1-cycle pulse.
- get_rdid pulse in IDLE starts a read. Pulses in any other state are ignored.
- reset_btn pulse is a synchronous soft clear:
  - ID registers go to 0x00.
  - A transaction in progress is aborted: chip_select=1, SPICLK=0, FSM to IDLE, same cycle.
- FSM states: IDLE -> CMD -> READ -> DONE -> IDLE.
  - CMD: 8 bits of RDID_CMD, MSB first.
  - READ: 24 bits.
  - DONE: 1 cycle.
- SPI timing:
  - SPICLK = CCLK/2, 25 MHz.
  - Each bit is 1 CCLK cycle low, then 1 cycle high.
  - chip_select falls on entry to CMD with SPIMOSI = bit 7 valid.
  - SPIMOSI changes only while SPICLK is low.
  - SPIMISO is sampled in the cycle SPICLK rises, READ phase only.
- 32 SPICLK periods = 64 CCLK cycles. chip_select returns high in DONE. SPICLK stays low when idle.
- Returned bytes in order: manufacturer ID, memory type, memory capacity.
- All three registers load atomically in DONE from the 24-bit shift register. A read in progress never alters the displayed values.
- LED mux, combinational:
  - SW=00: capacity.
  - SW=01: memory type.
  - SW=10: manufacturer ID.
  - SW=11: 0xFF.
- Latency from debounced press to capture: ≤70 CCLK cycles.
- A repeated read overwrites the registers with the fresh bytes (identical for the same device).

Decomposition:
- Shared package holds:
  - RDID_CMD.
  - FSM state encoding.
  - SW select codes.
- Sub-module spi_rdid_debounce: synchronizer + lock-out debouncer, instanced twice.
- Combinational LED selector instance named ledMux, output vector LED[7:0].
- FSM and shifter stay in the top.

Test Plan:
1. Idle after reset, SW = 00/01/10/11 -> LED = 0x00/0x00/0x00/0xFF; chip_select=1; SPICLK=0.
2. Flash model attached. Bouncy get_rdid_btn press (0.5 ns bounces) held 1.31 ms, bouncy release -> exactly one transaction:
   - 32 SPICLK pulses, 40 ns period.
   - MOSI carries 0x9F.
   - Then SW=00 -> 0x15, 01 -> 0x20, 10 -> 0x20, 11 -> 0xFF, checked at about 1.3124 ms.
3. Release bounces after lock-out expiry -> no second transaction (chip_select stays high).
4. Second bouncy press 2 ms after release -> new transaction; same LED values 0x15/0x20/0x20/0xFF after 3.3 ms.
5. reset_btn pulse mid-transaction -> chip_select high within 1 cycle after the debounced edge; LEDs 0x00 for SW 00–10.
6. rst_n asserted mid-transaction -> all outputs at reset values immediately (asynchronous).
